// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential 32-bit radix-2 restoring divider (DIV/DIVU/REM/REMU)

package div_seq_pkg;

    typedef enum logic [6:0] {
        ALU_ADD  = 7'h00,
        ALU_SUB  = 7'h01,
        ALU_DIV  = 7'h20,
        ALU_DIVU = 7'h21,
        ALU_REM  = 7'h22,
        ALU_REMU = 7'h23
    } alu_opcode_e;

endpackage

module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [6:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              illegal_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [DATA_W-1:0] ONE     = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [4:0]        LAST_IT = 5'd31;

    state_e            state_q;
    logic [4:0]        cnt_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic              q_neg_q;
    logic              r_neg_q;
    logic              rem_sel_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] result_q;
    logic              illegal_q;

    // Request decode: legality, sign handling, magnitudes and the early-exit results
    logic              op_legal_d;
    logic              op_signed_d;
    logic              op_rem_d;
    logic              a_neg_d;
    logic              b_neg_d;
    logic [DATA_W-1:0] a_mag_d;
    logic [DATA_W-1:0] b_mag_d;
    logic              div_zero_d;
    logic              overflow_d;
    logic [DATA_W-1:0] special_res_d;

    always_comb begin
        op_legal_d    = (op_i == ALU_DIV)  || (op_i == ALU_DIVU) ||
                        (op_i == ALU_REM)  || (op_i == ALU_REMU);
        op_signed_d   = (op_i == ALU_DIV)  || (op_i == ALU_REM);
        op_rem_d      = (op_i == ALU_REM)  || (op_i == ALU_REMU);
        a_neg_d       = op_signed_d && a_i[DATA_W-1];
        b_neg_d       = op_signed_d && b_i[DATA_W-1];
        a_mag_d       = a_neg_d ? ((~a_i) + ONE) : a_i;
        b_mag_d       = b_neg_d ? ((~b_i) + ONE) : b_i;
        div_zero_d    = (b_i == '0);
        overflow_d    = op_signed_d && (a_i == INT_MIN) && (b_i == '1);
        special_res_d = '0;
        if (div_zero_d) begin
            special_res_d = op_rem_d ? a_i : '1;
        end else if (overflow_d) begin
            special_res_d = op_rem_d ? '0 : INT_MIN;
        end
    end

    // One restoring step: the borrow out of the 33-bit subtract decides the quotient bit.
    // The shifted remainder is always below twice the divisor, so bit 32 of the
    // difference is set exactly when the subtraction underflowed.
    logic [DATA_W:0]   rem_sh_d;
    logic [DATA_W:0]   diff_d;
    logic              rem_ge_d;
    logic [DATA_W-1:0] rem_nxt_d;

    always_comb begin
        rem_sh_d  = {rem_q, dvd_q[DATA_W-1]};
        diff_d    = rem_sh_d - {1'b0, dvs_q};
        rem_ge_d  = ~diff_d[DATA_W];
        rem_nxt_d = rem_ge_d ? diff_d[DATA_W-1:0] : rem_sh_d[DATA_W-1:0];
    end

    // Sign correction and quotient/remainder selection applied in FIX
    logic [DATA_W-1:0] fix_res_d;

    always_comb begin
        fix_res_d = '0;
        if (rem_sel_q) begin
            fix_res_d = r_neg_q ? ((~rem_q) + ONE) : rem_q;
        end else begin
            fix_res_d = q_neg_q ? ((~quo_q) + ONE) : quo_q;
        end
    end

    // Control FSM with datapath registers and registered result outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            rem_sel_q   <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
        end else if (flush_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        if (!op_legal_d) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= '0;
                            illegal_q   <= 1'b1;
                        end else if (div_zero_d || overflow_d) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= special_res_d;
                            illegal_q   <= 1'b0;
                        end else begin
                            state_q   <= CALC;
                            cnt_q     <= '0;
                            rem_q     <= '0;
                            quo_q     <= '0;
                            dvd_q     <= a_mag_d;
                            dvs_q     <= b_mag_d;
                            q_neg_q   <= a_neg_d ^ b_neg_d;
                            r_neg_q   <= a_neg_d;
                            rem_sel_q <= op_rem_d;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt_d;
                    quo_q <= {quo_q[DATA_W-2:0], rem_ge_d};
                    dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_IT) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                    result_q    <= fix_res_d;
                    illegal_q   <= 1'b0;
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        result_q    <= '0;
                        illegal_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE) && !flush_i;
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign illegal_o   = illegal_q;

endmodule
